// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------------------
// noc_pkg -- shared NoC definitions.
//   iq_state_e    : control FSM encoding for vc_input_queue.
//   vc_idx_width  : bit width needed to index V virtual channels (min 1).
// ---------------------------------------------------------------------------
package noc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } iq_state_e;

  function automatic int vc_idx_width(input int num_vc);
    return (num_vc > 1) ? $clog2(num_vc) : 1;
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// ---------------------------------------------------------------------------
// vc_fifo -- single-clock FIFO holding one virtual channel's flits.
// Parameters: DATA_WIDTH (entry width), ADDR_WIDTH (log2 depth).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_en, wr_data    push (caller must not push while full)
//   rd_en, rd_data    pop; rd_data shows the head combinationally
//   empty, full       occupancy flags
// A push to an empty FIFO is visible on rd_data only from the next cycle.
// ---------------------------------------------------------------------------
module vc_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;

  logic w_push;
  logic w_pop;

  assign empty   = (r_count == '0);
  assign full    = (r_count == FULL_CNT);
  assign w_push  = wr_en;
  assign w_pop   = rd_en && !empty;
  assign rd_data = r_mem[r_rd_ptr];

  // NOTE: non-blocking (<=) for every register so all flops update together
  // at the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers and count define validity, and
  // leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/vc_input_queue.sv
// ---------------------------------------------------------------------------
// vc_input_queue -- router input port with V virtual-channel FIFOs and a
// three-state (IDLE/LOAD/SEND) issue FSM that serves VCs round-robin and
// holds each flit until every destination port has granted it.
// Parameters: FW flit width, P output ports, V VCs, B log2 slots per VC.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   flit_in_wr         push strobe for {dest_in, flit_in} into VC vc_in
//   flit_in, vc_in, dest_in
//   flit_rel[V]        one-cycle credit pulse when a VC's head is popped
//   dest_port_req[P]   ports still owed the current flit (0 in IDLE)
//   grant_dest_port[P] grants from the output arbiters
//   flit_to_crossbar   flit being offered (0 in IDLE)
//   vc_active          VC currently being served
//   ovf_err            sticky push-to-full flag, only with the
//                      IQ_OVERFLOW_CHK_EN macro defined
// ---------------------------------------------------------------------------
module vc_input_queue
  import noc_pkg::*;
#(
  parameter int FW = 64,
  parameter int P  = 7,
  parameter int V  = 2,
  parameter int B  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flit_in_wr,
  input  logic [FW-1:0]                flit_in,
  input  logic [vc_idx_width(V)-1:0]   vc_in,
  input  logic [P-1:0]                 dest_in,
  output logic [V-1:0]                 flit_rel,
  output logic [P-1:0]                 dest_port_req,
  input  logic [P-1:0]                 grant_dest_port,
  output logic [FW-1:0]                flit_to_crossbar,
  output logic [vc_idx_width(V)-1:0]   vc_active
`ifdef IQ_OVERFLOW_CHK_EN
  ,
  output logic                         ovf_err
`endif
);

  localparam int VW = vc_idx_width(V);
  localparam int EW = P + FW;  // FIFO entry = {dest, flit}

  iq_state_e r_state;
  iq_state_e w_state_next;

  logic [VW-1:0] r_rr_ptr;     // first VC to consider on the next pick
  logic [VW-1:0] r_vc_active;
  logic [FW-1:0] r_flit;
  logic [P-1:0]  r_remaining;  // ports not yet granted for r_flit

  logic [V-1:0]  w_empty;
  logic [V-1:0]  w_full;
  logic [V-1:0]  w_vc_hit;
  logic [V-1:0]  w_wr_en;
  logic [V-1:0]  w_rd_en;
  logic [EW-1:0] w_rd_data [V];
  logic [EW-1:0] w_head;

  logic          w_any;
  logic [VW-1:0] w_sel;
  logic [VW-1:0] w_rr_next;
  logic          w_pop;
  logic [P-1:0]  w_rem_next;

  // -------------------------------------------------------------------------
  // Per-VC FIFOs. Pushes to a full VC are dropped here so the FIFO never sees
  // them and its contents stay intact.
  // -------------------------------------------------------------------------
  for (genvar g = 0; g < V; g++) begin : g_vc
    assign w_vc_hit[g] = (vc_in == VW'(g));
    assign w_wr_en[g]  = flit_in_wr && w_vc_hit[g] && !w_full[g];
    assign w_rd_en[g]  = w_pop && (w_sel == VW'(g));

    vc_fifo #(
      .DATA_WIDTH (EW),
      .ADDR_WIDTH (B)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (w_wr_en[g]),
      .wr_data ({dest_in, flit_in}),
      .rd_en   (w_rd_en[g]),
      .rd_data (w_rd_data[g]),
      .empty   (w_empty[g]),
      .full    (w_full[g])
    );
  end

  assign w_head = w_rd_data[w_sel];

  // -------------------------------------------------------------------------
  // Round-robin pick. Scanning offsets from farthest to nearest and letting
  // the last hit win yields the first non-empty VC at or after r_rr_ptr.
  // -------------------------------------------------------------------------
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned and no latch is inferred.
    w_any = |(~w_empty);
    w_sel = '0;
    for (int i = V - 1; i >= 0; i--) begin
      idx = int'(r_rr_ptr) + i;
      if (idx >= V) idx = idx - V;
      if (!w_empty[idx]) w_sel = VW'(idx);
    end
    w_rr_next = (w_sel == VW'(V - 1)) ? '0 : w_sel + VW'(1);
  end

  // -------------------------------------------------------------------------
  // FSM next-state and outputs.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: blocking (=) in combinational logic so later statements see the
    // values assigned above them within the same evaluation.
    w_state_next     = r_state;
    w_pop            = 1'b0;
    flit_rel         = '0;
    dest_port_req    = '0;
    flit_to_crossbar = '0;
    // Grant bits outside r_remaining fall out of the AND and have no effect.
    w_rem_next       = r_remaining & ~grant_dest_port;

    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_pop           = 1'b1;
          flit_rel[w_sel] = 1'b1;
          w_state_next    = ST_LOAD;
        end
      end
      ST_LOAD, ST_SEND: begin
        dest_port_req    = r_remaining;
        flit_to_crossbar = r_flit;
        // A zero dest also lands here: the flit is dropped after one cycle.
        w_state_next     = (w_rem_next == '0) ? ST_IDLE : ST_SEND;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // The head is captured on the popping edge, so in LOAD the hold registers
  // already present the popped flit and its full destination vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_vc_active <= '0;
      r_flit      <= '0;
      r_remaining <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_pop) begin
        r_vc_active <= w_sel;
        r_rr_ptr    <= w_rr_next;
        r_flit      <= w_head[FW-1:0];
        r_remaining <= w_head[EW-1:FW];
      end else if (r_state != ST_IDLE) begin
        r_remaining <= w_rem_next;
      end
    end
  end

  assign vc_active = r_vc_active;

`ifdef IQ_OVERFLOW_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_err <= 1'b0;
    end else if (flit_in_wr && |(w_vc_hit & w_full)) begin
      ovf_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vc_input_queue.sv
// ---------------------------------------------------------------------------
// tb_vc_input_queue -- scoreboard bench for vc_input_queue (FW=64, P=7, V=2,
// B=2). Directed tests push hand-computed expectations into two queues:
// credit pulses and flit deliveries (cycles where req & grant != 0). A
// monitor on the falling edge pops and compares whenever the DUT shows one.
// ---------------------------------------------------------------------------
module tb_vc_input_queue;
  import noc_pkg::*;

  localparam int FW = 64;
  localparam int P  = 7;
  localparam int V  = 2;
  localparam int B  = 2;
  localparam int VW = vc_idx_width(V);

  logic          clk = 1'b0;
  logic          rst;
  logic          flit_in_wr;
  logic [FW-1:0] flit_in;
  logic [VW-1:0] vc_in;
  logic [P-1:0]  dest_in;
  logic [V-1:0]  flit_rel;
  logic [P-1:0]  dest_port_req;
  logic [P-1:0]  grant_dest_port;
  logic [FW-1:0] flit_to_crossbar;
  logic [VW-1:0] vc_active;
`ifdef IQ_OVERFLOW_CHK_EN
  logic          ovf_err;
`endif

  vc_input_queue #(.FW(FW), .P(P), .V(V), .B(B)) dut (
    .clk              (clk),
    .rst              (rst),
    .flit_in_wr       (flit_in_wr),
    .flit_in          (flit_in),
    .vc_in            (vc_in),
    .dest_in          (dest_in),
    .flit_rel         (flit_rel),
    .dest_port_req    (dest_port_req),
    .grant_dest_port  (grant_dest_port),
    .flit_to_crossbar (flit_to_crossbar),
    .vc_active        (vc_active)
`ifdef IQ_OVERFLOW_CHK_EN
    ,
    .ovf_err          (ovf_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [P-1:0]  req;
    logic [P-1:0]  del;
    logic [FW-1:0] flit;
    logic [VW-1:0] vc;
  } xfer_t;

  xfer_t        exp_xfer_q[$];
  logic [V-1:0] exp_rel_q[$];
  logic [P-1:0] grant_q[$];
  logic         auto_grant = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_xfer(input logic [P-1:0] req, input logic [P-1:0] del,
                          input logic [FW-1:0] flit, input logic [VW-1:0] vc);
    xfer_t e;
    e.req = req; e.del = del; e.flit = flit; e.vc = vc;
    exp_xfer_q.push_back(e);
  endtask

  task automatic push(input logic [VW-1:0] vc, input logic [P-1:0] dest,
                      input logic [FW-1:0] flit);
    flit_in_wr = 1'b1;
    vc_in      = vc;
    dest_in    = dest;
    flit_in    = flit;
    @(posedge clk);
    #1;
    flit_in_wr = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while ((exp_xfer_q.size() != 0 || exp_rel_q.size() != 0 ||
            dest_port_req != '0) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (cyc >= 200) begin
      n_fail++;
      $display("FAIL %s_drain: timed out with %0d xfers / %0d credits pending",
               name, exp_xfer_q.size(), exp_rel_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // Grant driver: either mirrors the request or replays a scripted grant
  // each cycle a request is up.
  initial begin
    grant_dest_port = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst)                                        grant_dest_port = '0;
      else if (auto_grant)                            grant_dest_port = dest_port_req;
      else if (dest_port_req != '0 && grant_q.size() > 0) grant_dest_port = grant_q.pop_front();
      else                                            grant_dest_port = '0;
    end
  end

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && flit_rel != '0) begin
        if (exp_rel_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL rel_unexpected: got 0x%0h, expected no credit", flit_rel);
        end else begin
          check("flit_rel", 64'(flit_rel), 64'(exp_rel_q.pop_front()));
        end
      end
      if (!rst && (dest_port_req & grant_dest_port) != '0) begin
        if (exp_xfer_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL xfer_unexpected: got req 0x%0h flit 0x%0h, expected none",
                   dest_port_req, flit_to_crossbar);
        end else begin
          xfer_t e;
          e = exp_xfer_q.pop_front();
          check("xfer_req",  64'(dest_port_req), 64'(e.req));
          check("xfer_del",  64'(dest_port_req & grant_dest_port), 64'(e.del));
          check("xfer_flit", flit_to_crossbar, e.flit);
          check("xfer_vc",   64'(vc_active), 64'(e.vc));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    flit_in_wr = 1'b0;
    flit_in    = '0;
    vc_in      = '0;
    dest_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rel",  64'(flit_rel), 64'h0);
    check("rst_req",  64'(dest_port_req), 64'h0);
    check("rst_flit", flit_to_crossbar, 64'h0);
    check("rst_vc",   64'(vc_active), 64'h0);
`ifdef IQ_OVERFLOW_CHK_EN
    check("rst_ovf",  64'(ovf_err), 64'h0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Unicast: credit in cycle 1, request+flit in cycle 2, idle in cycle 3.
    grant_q.push_back(7'b0000100);
    exp_rel_q.push_back(2'b01);
    exp_xfer(7'b0000100, 7'b0000100, 64'hA5, 1'b0);
    push(1'b0, 7'b0000100, 64'hA5);
    @(negedge clk);
    check("uni_c1_rel", 64'(flit_rel), 64'h1);
    @(negedge clk);
    check("uni_c2_req",  64'(dest_port_req), 64'h04);
    check("uni_c2_flit", flit_to_crossbar, 64'hA5);
    @(negedge clk);
    check("uni_c3_req", 64'(dest_port_req), 64'h0);
    wait_drain("unicast");

    // Multicast with partial grants over three cycles; flit held constant.
    grant_q.push_back(7'b0000001);
    grant_q.push_back(7'b0010000);
    grant_q.push_back(7'b0000010);
    exp_rel_q.push_back(2'b01);
    exp_xfer(7'b0010011, 7'b0000001, 64'h1122_3344_5566_7788, 1'b0);
    exp_xfer(7'b0010010, 7'b0010000, 64'h1122_3344_5566_7788, 1'b0);
    exp_xfer(7'b0000010, 7'b0000010, 64'h1122_3344_5566_7788, 1'b0);
    push(1'b0, 7'b0010011, 64'h1122_3344_5566_7788);
    wait_drain("multicast");
    check("mc_after_req", 64'(dest_port_req), 64'h0);

    // Fairness: alternating pushes, round-robin serves 0,1,0,1,0,1.
    auto_grant = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_rel_q.push_back(2'b01);
      exp_xfer(7'b0000001, 7'b0000001, 64'hA0 + 64'(i), 1'b0);
      exp_rel_q.push_back(2'b10);
      exp_xfer(7'b0000010, 7'b0000010, 64'hB0 + 64'(i), 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      push(1'b0, 7'b0000001, 64'hA0 + 64'(i));
      push(1'b1, 7'b0000010, 64'hB0 + 64'(i));
    end
    wait_drain("fairness");

    // Overflow: VC0 flit parked in SEND, five pushes to VC1 keep only four.
    @(negedge clk);
    auto_grant = 1'b0;
    exp_rel_q.push_back(2'b01);
    push(1'b0, 7'b0000001, 64'hC0);
    repeat (2) @(negedge clk);
    check("ovf_parked_req", 64'(dest_port_req), 64'h01);
    for (int i = 1; i <= 5; i++) begin
      push(1'b1, 7'b0000010, 64'hC0 + 64'(i));
`ifdef IQ_OVERFLOW_CHK_EN
      if (i == 4) check("ovf_before", 64'(ovf_err), 64'h0);
      if (i == 5) check("ovf_after",  64'(ovf_err), 64'h1);
`endif
    end
    exp_xfer(7'b0000001, 7'b0000001, 64'hC0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      exp_rel_q.push_back(2'b10);
      exp_xfer(7'b0000010, 7'b0000010, 64'hC0 + 64'(i), 1'b1);
    end
    @(negedge clk);
    auto_grant = 1'b1;
    wait_drain("overflow");
`ifdef IQ_OVERFLOW_CHK_EN
    check("ovf_sticky", 64'(ovf_err), 64'h1);
`endif

    // Zero dest: credit returned, never requested.
    @(negedge clk);
    auto_grant = 1'b0;
    exp_rel_q.push_back(2'b01);
    push(1'b0, 7'b0000000, 64'hD0);
    @(negedge clk);
    @(negedge clk);
    check("zero_load_req", 64'(dest_port_req), 64'h0);
    wait_drain("zero_dest");

    // Stray grant on an unrequested port leaves SEND untouched.
    grant_q.push_back(7'b0000000);
    grant_q.push_back(7'b0000010);
    grant_q.push_back(7'b0000001);
    exp_rel_q.push_back(2'b01);
    exp_xfer(7'b0000001, 7'b0000001, 64'hD1, 1'b0);
    push(1'b0, 7'b0000001, 64'hD1);
    @(negedge clk);
    @(negedge clk);
    check("stray_load_req", 64'(dest_port_req), 64'h01);
    @(negedge clk);
    check("stray_send_req", 64'(dest_port_req), 64'h01);
    @(negedge clk);
    check("stray_final_req", 64'(dest_port_req), 64'h01);
    @(negedge clk);
    check("stray_idle_req", 64'(dest_port_req), 64'h0);
    wait_drain("stray");

    // Reset mid-SEND: VC1 flit parked, VC0 holds one more entry.
    exp_rel_q.push_back(2'b10);
    push(1'b1, 7'b0000001, 64'hE0);
    push(1'b0, 7'b0000001, 64'hE1);
    repeat (3) @(negedge clk);
    check("mid_send_vc",  64'(vc_active), 64'h1);
    check("mid_send_req", 64'(dest_port_req), 64'h01);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rel",  64'(flit_rel), 64'h0);
    check("post_rst_req",  64'(dest_port_req), 64'h0);
    check("post_rst_flit", flit_to_crossbar, 64'h0);
    check("post_rst_vc",   64'(vc_active), 64'h0);
`ifdef IQ_OVERFLOW_CHK_EN
    check("post_rst_ovf",  64'(ovf_err), 64'h0);
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_quiet", 64'(flit_rel), 64'h0);
    end
    // A fresh flit must be the first thing out of VC0 (old entry flushed).
    auto_grant = 1'b1;
    exp_rel_q.push_back(2'b01);
    exp_xfer(7'b0000001, 7'b0000001, 64'hF0, 1'b0);
    push(1'b0, 7'b0000001, 64'hF0);
    wait_drain("post_reset");

    check("end_xfer_q", 64'(exp_xfer_q.size()), 64'h0);
    check("end_rel_q",  64'(exp_rel_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
